// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the command-driven APB master.
package apb_master_pkg;

   localparam int ADDR_W_DEF  = 8;
   localparam int DATA_W_DEF  = 32;
   localparam int TIMEOUT_DEF = 16;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_state_e;

   typedef struct packed {
      logic                  write;
      logic [ADDR_W_DEF-1:0] addr;
      logic [DATA_W_DEF-1:0] wdata;
   } apb_cmd_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Saturating ACCESS-phase wait counter; expired flags the LIMIT-th enabled cycle.
module apb_timeout_cnt #(
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;
   logic          last;

   assign last    = (cnt == CW'(LIMIT - 1));
   assign expired = en && last;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (en && !last)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/apb_master.sv
// Single-transfer APB master driven by a valid/ready command/response pair.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles.
module apb_master
   import apb_master_pkg::*;
#(
   parameter int ADDR_W         = ADDR_W_DEF,
   parameter int DATA_W         = DATA_W_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [DATA_W-1:0] cmd_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic [ADDR_W-1:0] PADDR,
   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [DATA_W-1:0] PWDATA,
   input  logic              PREADY,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PSLVERR
);

   apb_state_e state;
   logic       tmo_expired;

`ifdef APB_MASTER_TIMEOUT_EN
   apb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_tmo (
      .clk     (PCLK),
      .rst     (PRESET),
      .clr     (state == SETUP),
      .en      (state == ACCESS && !PREADY),
      .expired (tmo_expired)
   );
`else
   // Without the timeout, ACCESS only ever leaves on PREADY.
   assign tmo_expired = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state     <= IDLE;
         cmd_ready <= 1'b0;
         PSEL      <= 1'b0;
         PENABLE   <= 1'b0;
         PWRITE    <= 1'b0;
         PADDR     <= '0;
         PWDATA    <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               cmd_ready <= 1'b1;
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  PWRITE    <= cmd_write;
                  PADDR     <= cmd_addr;
                  PWDATA    <= cmd_wdata;
                  PSEL      <= 1'b1;
                  state     <= SETUP;
               end
            end
            SETUP: begin
               PENABLE <= 1'b1;
               state   <= ACCESS;
            end
            ACCESS: begin
               if (PREADY) begin
                  rsp_rdata <= PWRITE ? '0 : PRDATA;
                  rsp_err   <= PSLVERR;
               end else if (tmo_expired) begin
                  rsp_rdata <= '0;
                  rsp_err   <= 1'b1;
               end
               if (PREADY || tmo_expired) begin
                  PSEL      <= 1'b0;
                  PENABLE   <= 1'b0;
                  rsp_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master against a per-transfer timeline model.
module tb_apb_master;
   import apb_master_pkg::*;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif
   localparam int TMO = 16;

   logic        PCLK = 1'b0;
   logic        PRESET = 1'b1;
   logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
   logic [7:0]  cmd_addr = '0;
   logic [31:0] cmd_wdata = '0;
   logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [31:0] rsp_rdata;
   logic [7:0]  PADDR;
   logic        PSEL, PENABLE, PWRITE;
   logic [31:0] PWDATA;
   logic        PREADY = 1'b0, PSLVERR = 1'b0;
   logic [31:0] PRDATA = '0;

   apb_master #(.ADDR_W(8), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
   );

   always #5 PCLK = ~PCLK;

   int n_tests = 0, n_fail = 0;
   bit chk_on = 1'b0;

   // Expected outputs for the current cycle.
   logic        e_rdy, e_psel, e_pen, e_pw, e_rv, e_er;
   logic [7:0]  e_pa;
   logic [31:0] e_pd, e_rd;

   // Observations used for the literal latency/data pins.
   int          cyc = 0, hs_cyc = 0, rv_cyc = 0, acc_cnt = 0;
   logic        rv_prev = 1'b0, rv_err = 1'b0, setup_wr = 1'b0;
   logic [31:0] rv_rdata = '0, setup_wdata = '0;
   logic [7:0]  setup_addr = '0;

   always @(posedge PCLK) begin
      cyc <= cyc + 1;
      if (!PRESET && cmd_valid && cmd_ready) hs_cyc <= cyc + 1;
   end

   always @(negedge PCLK) begin
      if (rsp_valid && !rv_prev) begin
         rv_cyc   <= cyc;
         rv_rdata <= rsp_rdata;
         rv_err   <= rsp_err;
      end
      rv_prev <= rsp_valid;
      if (PSEL && !PENABLE) begin
         acc_cnt     <= 0;
         setup_addr  <= PADDR;
         setup_wdata <= PWDATA;
         setup_wr    <= PWRITE;
      end else if (PENABLE) begin
         acc_cnt <= acc_cnt + 1;
      end
   end

   always @(negedge PCLK) begin
      if (chk_on) begin
         n_tests++;
         if (cmd_ready !== e_rdy || PSEL !== e_psel || PENABLE !== e_pen || PWRITE !== e_pw ||
             PADDR !== e_pa || PWDATA !== e_pd || rsp_valid !== e_rv || (PENABLE && !PSEL) ||
             (e_rv && (rsp_rdata !== e_rd || rsp_err !== e_er))) begin
            n_fail++;
            $display("FAIL cycle %0d: got rdy=%b sel=%b en=%b wr=%b a=%h wd=%h rv=%b rd=%h er=%b; expected rdy=%b sel=%b en=%b wr=%b a=%h wd=%h rv=%b rd=%h er=%b",
                     cyc, cmd_ready, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid, rsp_rdata, rsp_err,
                     e_rdy, e_psel, e_pen, e_pw, e_pa, e_pd, e_rv, e_rd, e_er);
         end
      end
   end

   function automatic void check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endfunction

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic exp_idle();
      e_rdy = 1'b1; e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b0;
   endtask

   task automatic junk();
      cmd_valid = 1'($urandom);
      cmd_write = 1'($urandom);
      cmd_addr  = 8'($urandom);
      cmd_wdata = $urandom;
      PREADY    = 1'($urandom);
      PRDATA    = $urandom;
      PSLVERR   = 1'($urandom);
   endtask

   // One full transfer from an IDLE cycle back to the next IDLE cycle.
   task automatic xfer(input apb_cmd_t c, input int gap, input int waits,
                       input logic [31:0] rd, input bit err, input int hold);
      bit tmo;
      int nacc;
      tmo  = TMO_EN && (waits >= TMO);
      nacc = tmo ? TMO : waits + 1;
      rsp_ready = 1'b0;
      for (int i = 0; i < gap; i++) begin
         junk(); cmd_valid = 1'b0; exp_idle(); step();
      end
      junk();
      cmd_valid = 1'b1; cmd_write = c.write; cmd_addr = c.addr; cmd_wdata = c.wdata;
      exp_idle();
      step();
      e_rdy = 1'b0; e_psel = 1'b1; e_pen = 1'b0;
      e_pw = c.write; e_pa = c.addr; e_pd = c.wdata;
      junk(); step();
      e_pen = 1'b1;
      for (int i = 0; i < nacc; i++) begin
         junk();
         PREADY  = (i == waits);
         PRDATA  = (i == waits) ? rd : $urandom;
         PSLVERR = (i == waits) ? err : 1'($urandom);
         step();
      end
      e_psel = 1'b0; e_pen = 1'b0; e_rv = 1'b1;
      e_rd = (tmo || c.write) ? 32'h0 : rd;
      e_er = tmo ? 1'b1 : err;
      for (int j = 0; j <= hold; j++) begin
         junk();
         rsp_ready = (j == hold);
         step();
      end
      rsp_ready = 1'b0; cmd_valid = 1'b0;
      e_rv = 1'b0; e_rdy = 1'b1;
   endtask

   task automatic do_reset(input int n);
      chk_on = 1'b0; PRESET = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
      step();
      for (int i = 0; i < n; i++) begin
         check("reset_outputs_zero",
               {cmd_ready, PSEL, PENABLE, PWRITE, PADDR, rsp_valid, rsp_err, PWDATA != 0, rsp_rdata != 0},
               64'h0);
         step();
      end
      PRESET = 1'b0;
      e_rdy = 1'b0; e_psel = 1'b0; e_pen = 1'b0; e_pw = 1'b0;
      e_pa = '0; e_pd = '0; e_rv = 1'b0; e_rd = '0; e_er = 1'b0;
      chk_on = 1'b1;
      step();
      e_rdy = 1'b1;
      check("cmd_ready_after_release", cmd_ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      apb_cmd_t c;
      int lat;

      do_reset(10);

      // Write, PREADY immediately high.
      c = '{write: 1'b1, addr: 8'h10, wdata: 32'h5A5A_0001};
      xfer(c, 0, 0, 32'hFFFF_FFFF, 1'b0, 0);
      lat = rv_cyc - hs_cyc + 1;
      check("write_latency", lat, 3);
      check("write_setup_addr", setup_addr, 8'h10);
      check("write_setup_pwrite", setup_wr, 1);
      check("write_setup_wdata", setup_wdata, 32'h5A5A_0001);
      check("write_rdata_zero", rv_rdata, 0);
      check("write_err", rv_err, 0);

      // Read with three wait states.
      c = '{write: 1'b0, addr: 8'h10, wdata: 32'h1234_5678};
      xfer(c, 1, 3, 32'hDEAD_BEEF, 1'b0, 0);
      lat = rv_cyc - hs_cyc + 1;
      check("read_wait_latency", lat, 6);
      check("read_access_cycles", acc_cnt, 4);
      check("read_rdata", rv_rdata, 32'hDEAD_BEEF);

      // Slave error with five cycles of response backpressure.
      c = '{write: 1'b0, addr: 8'h24, wdata: 32'h0};
      xfer(c, 0, 1, 32'h0BAD_F00D, 1'b1, 5);
      check("slverr_err", rv_err, 1);
      check("slverr_rdata", rv_rdata, 32'h0BAD_F00D);

      // Back-to-back at full rate.
      for (int i = 0; i < 3; i++) begin
         c = '{write: 1'($urandom), addr: 8'($urandom), wdata: $urandom};
         xfer(c, 0, 0, $urandom, 1'b0, 0);
      end

      // Reset in the middle of ACCESS.
      chk_on = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h33; cmd_wdata = 32'hCAFE_0033;
      step();
      cmd_valid = 1'b0; PREADY = 1'b0;
      step();
      step();
      check("midrst_in_access", {PSEL, PENABLE}, 2'b11);
      PRESET = 1'b1;
      #1;
      check("midrst_psel_drop", PSEL, 0);
      check("midrst_penable_drop", PENABLE, 0);
      do_reset(3);
      c = '{write: 1'b0, addr: 8'h44, wdata: 32'h0};
      xfer(c, 2, 0, 32'h0044_4444, 1'b0, 1);
      check("post_reset_read", rv_rdata, 32'h0044_4444);

      // Stuck slave: aborts after TMO cycles or keeps waiting.
      c = '{write: 1'b0, addr: 8'h55, wdata: 32'h0};
      xfer(c, 0, 120, 32'h5555_5555, 1'b0, 0);
      if (TMO_EN) begin
         check("timeout_access_cycles", acc_cnt, TMO);
         check("timeout_err", rv_err, 1);
         check("timeout_rdata", rv_rdata, 0);
      end else begin
         check("no_timeout_long_access", acc_cnt >= 100, 1);
         check("no_timeout_rdata", rv_rdata, 32'h5555_5555);
      end

      // Randomized traffic.
      for (int i = 0; i < 40; i++) begin
         c = '{write: 1'($urandom), addr: 8'($urandom), wdata: $urandom};
         xfer(c, $urandom_range(0, 2), $urandom_range(0, 4), $urandom,
              1'($urandom), $urandom_range(0, 3));
      end

      chk_on = 1'b0;
      step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
